// File: rtl/cg_rvarch_pkg.sv
// Shared RISC-V architectural constants and the writeback request record.
package cg_rvarch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = $clog2(32);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/cg_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from a rotating pointer that
// moves just past the winner on every grant.
module cg_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] k;
  logic            found;

  // Walk ptr, ptr+1, ... with wrap; the first requester seen wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    sum       = '0;
    k         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (IdxW + 1)'(i);
      k   = (sum >= (IdxW + 1)'(N)) ? IdxW'(sum - (IdxW + 1)'(N)) : IdxW'(sum);
      if (i_en && !found && i_req[k]) begin
        found     = 1'b1;
        o_gnt[k]  = 1'b1;
        o_gnt_idx = k;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (o_gnt_idx == IdxW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cg_rvarch_wb_arbiter.sv
// Register-file writeback arbiter: round-robin selection among requesters feeding a
// single registered write port; writes to x0 are accepted but never enabled.
module cg_rvarch_wb_arbiter
  import cg_rvarch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned DATA_NUM   = 1 << REG_ADDR_W,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_hold,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic [NUM_REQ*$clog2(DATA_NUM)-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
  output logic [$clog2(DATA_NUM)-1:0]        o_rd_addr,
  output logic                               o_rd_we,
  output logic [DATA_WIDTH-1:0]              o_rd_data,
  output logic [$clog2(NUM_REQ)-1:0]         o_grant_id
);

  localparam int unsigned AW = $clog2(DATA_NUM);
  localparam int unsigned GW = $clog2(NUM_REQ);

  logic          arb_en;
  logic [GW-1:0] gnt_idx;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Reset gates the grant too, so nothing is handed out while i_rst is high.
  assign arb_en = !i_hold && !i_rst;

  cg_rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (arb_en),
    .i_req    (i_req_valid),
    .o_gnt    (o_req_ready),
    .o_gnt_idx(gnt_idx)
  );

  assign accept   = |o_req_ready;
  assign sel_addr = i_req_addr[gnt_idx*AW +: AW];
  assign sel_data = i_req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_we    <= 1'b0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_grant_id <= '0;
    end else if (accept) begin
      o_rd_we    <= (sel_addr != '0);
      o_rd_addr  <= sel_addr;
      o_rd_data  <= sel_data;
      o_grant_id <= gnt_idx;
    end else begin
      o_rd_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cg_rvarch_wb_arbiter.sv
// Bench for cg_rvarch_wb_arbiter: directed vector table, corner sequences, and a
// random phase checked against a queue-free round-robin reference model.
module tb_cg_rvarch_wb_arbiter;
  import cg_rvarch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [14:0] abus;
  logic [95:0] dbus;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] rd_data;
  logic [1:0]  gid;

  always #5 clk = ~clk;

  cg_rvarch_wb_arbiter #(
    .DATA_WIDTH(32),
    .DATA_NUM  (32),
    .NUM_REQ   (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_hold     (hold),
    .i_req_valid(valid),
    .o_req_ready(ready),
    .i_req_addr (abus),
    .i_req_data (dbus),
    .o_rd_addr  (rd_addr),
    .o_rd_we    (rd_we),
    .o_rd_data  (rd_data),
    .o_grant_id (gid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_ptr  = 0;
  bit          m_we   = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_gid  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst || hold) return -1;
    for (int i = 0; i < 3; i++) begin
      if (valid[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
    end
    return -1;
  endfunction

  function automatic void model_clock(input int g);
    if (rst) begin
      m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_gid = 0;
    end else if (g >= 0) begin
      m_ptr  = (g + 1) % 3;
      m_addr = abus[g*5 +: 5];
      m_data = dbus[g*32 +: 32];
      m_we   = (m_addr != 5'd0);
      m_gid  = g;
    end else begin
      m_we = 0;
    end
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Sample ready at the falling edge, clock the model and DUT, settle, return.
  task automatic run_cycle(output logic [2:0] rdy);
    int g;
    @(negedge clk);
    rdy = ready;
    g = model_grant();
    @(posedge clk);
    model_clock(g);
    #1;
  endtask

  typedef struct packed {
    logic        hold;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_gid;
  } vec_t;

  function automatic vec_t mk(input logic h, input logic [2:0] v, input logic [14:0] a,
                              input logic [95:0] d, input logic [2:0] er, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed,
                              input logic [1:0] eg);
    vec_t r;
    r.hold = h; r.valid = v; r.addr = a; r.data = d; r.exp_ready = er;
    r.exp_we = ew; r.exp_addr = ea; r.exp_data = ed; r.exp_gid = eg;
    return r;
  endfunction

  vec_t        tbl[$];
  logic [2:0]  r;
  bit          pend[3];
  wb_req_t     preq[3];
  int          g;

  initial begin
    logic [14:0] a3;
    logic [95:0] d3;
    a3 = {5'd9, 5'd8, 5'd6};
    d3 = {32'h90, 32'h80, 32'h60};
    tbl.push_back(mk(0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                     3'b010, 1, 5'd5, 32'hDEADBEEF, 2'd1));
    tbl.push_back(mk(0, 3'b000, '0, '0, 3'b000, 0, 5'd5, 32'hDEADBEEF, 2'd1));
    tbl.push_back(mk(0, 3'b001, '0, {64'h0, 32'h1234}, 3'b001, 0, 5'd0, 32'h1234, 2'd0));
    tbl.push_back(mk(0, 3'b011, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h22, 32'h11},
                     3'b010, 1, 5'd4, 32'h22, 2'd1));
    tbl.push_back(mk(0, 3'b001, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h22, 32'h11},
                     3'b001, 1, 5'd3, 32'h11, 2'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 3'b111, a3, d3, 3'b000, 0, 5'd3, 32'h11, 2'd0));
    tbl.push_back(mk(0, 3'b111, a3, d3, 3'b010, 1, 5'd8, 32'h80, 2'd1));
    tbl.push_back(mk(0, 3'b101, a3, d3, 3'b100, 1, 5'd9, 32'h90, 2'd2));
    tbl.push_back(mk(0, 3'b001, a3, d3, 3'b001, 1, 5'd6, 32'h60, 2'd0));
    tbl.push_back(mk(0, 3'b000, a3, d3, 3'b000, 0, 5'd6, 32'h60, 2'd0));

    // Reset held with every requester asking.
    rst = 1; hold = 0; valid = 3'b111;
    abus = {5'd3, 5'd2, 5'd1}; dbus = {32'hC, 32'hB, 32'hA};
    for (int i = 0; i < 3; i++) begin
      run_cycle(r);
      chk("rst_ready", {29'd0, r}, 32'd0);
      chk("rst_we", {31'd0, rd_we}, 32'd0);
      chk("rst_addr", {27'd0, rd_addr}, 32'd0);
    end
    rst = 0;
    @(negedge clk);
    chk("first_grant", {29'd0, ready}, 32'd1);
    valid = 3'b000;
    @(posedge clk);
    model_clock(-1);
    #1;

    // Directed table: single write, x0 drop, pointer after x0, hold, resume.
    foreach (tbl[i]) begin
      hold = tbl[i].hold; valid = tbl[i].valid; abus = tbl[i].addr; dbus = tbl[i].data;
      run_cycle(r);
      chk($sformatf("tbl%0d_ready", i), {29'd0, r}, {29'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_we", i), {31'd0, rd_we}, {31'd0, tbl[i].exp_we});
      chk($sformatf("tbl%0d_addr", i), {27'd0, rd_addr}, {27'd0, tbl[i].exp_addr});
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_gid", i), {30'd0, gid}, {30'd0, tbl[i].exp_gid});
    end
    hold = 0;

    // Fairness from a fresh pointer: all valid, fresh payload each cycle.
    rst = 1; valid = 3'b000;
    run_cycle(r);
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      valid = 3'b111;
      abus  = {5'd3, 5'd2, 5'd1};
      dbus  = {32'(200 + c), 32'(100 + c), 32'(c)};
      run_cycle(r);
      chk("fair_ready", {29'd0, r}, {29'd0, onehot(c % 3)});
      chk("fair_we", {31'd0, rd_we}, 32'd1);
      chk("fair_gid", {30'd0, gid}, 32'(c % 3));
      chk("fair_addr", {27'd0, rd_addr}, 32'(c % 3 + 1));
      chk("fair_data", rd_data, 32'((c % 3) * 100 + c));
    end
    valid = 3'b000;
    run_cycle(r);
    chk("fair_idle_we", {31'd0, rd_we}, 32'd0);

    // Asynchronous reset while a write sits in the output register.
    valid = 3'b100; abus = {5'd7, 5'd0, 5'd0}; dbus = {32'hAA, 64'h0};
    run_cycle(r);
    chk("async_ready", {29'd0, r}, 32'b100);
    chk("async_we_pre", {31'd0, rd_we}, 32'd1);
    chk("async_addr_pre", {27'd0, rd_addr}, 32'd7);
    chk("async_gid_pre", {30'd0, gid}, 32'd2);
    valid = 3'b000;
    #2;
    rst = 1;
    #1;
    chk("async_we", {31'd0, rd_we}, 32'd0);
    chk("async_addr", {27'd0, rd_addr}, 32'd0);
    chk("async_rdy", {29'd0, ready}, 32'd0);
    m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_gid = 0;
    @(posedge clk);
    #1;
    rst = 0; valid = 3'b111;
    @(negedge clk);
    chk("async_ptr0", {29'd0, ready}, 32'd1);
    valid = 3'b000;
    @(posedge clk);
    #1;

    // Random traffic obeying the hold-until-accepted protocol.
    for (int k = 0; k < 3; k++) pend[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k]      = 1;
          preq[k].addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          preq[k].data = $urandom;
        end
        valid[k]        = pend[k];
        abus[k*5 +: 5]  = preq[k].addr;
        dbus[k*32 +: 32] = preq[k].data;
      end
      hold = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      g = model_grant();
      chk("rnd_ready", {29'd0, ready}, {29'd0, onehot(g)});
      @(posedge clk);
      model_clock(g);
      if (g >= 0) pend[g] = 0;
      #1;
      chk("rnd_we", {31'd0, rd_we}, {31'd0, m_we});
      chk("rnd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
      chk("rnd_data", rd_data, m_data);
      chk("rnd_gid", {30'd0, gid}, 32'(m_gid));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
